i2c_write_sequencer: RTL and testbench

Command-level controller that sits between a host (register block or CPU bus slave) and I2C_Master. It sequences complete write transactions: START plus address byte, N data bytes drawn from an internal FIFO, then STOP. It drives the master's start/stop/i2c_en/tx_data command interface and consumes its ready/tx_done status. Master-side ports keep the master's names so the two blocks connect by name.

---
 rtl/i2c_seq_pkg.sv | 22 ++
 rtl/i2c_write_sequencer_if.sv | 44 ++++
 rtl/i2c_seq_fifo.sv | 73 +++++++
 rtl/i2c_write_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_i2c_write_sequencer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C write sequencer and its FIFO.
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_REQ,
    ADDR_WAIT,
    DATA_REQ,
    DATA_WAIT,
    STOP_REQ,
    STOP_WAIT
  } seq_state_e;

  localparam logic I2C_WR_BIT         = 1'b0;
  localparam int   DEFAULT_FIFO_DEPTH = 8;

  // Address byte as it goes on the wire for a write: 7-bit address, R/W# low.
  function automatic logic [7:0] addr_byte(input logic [6:0] addr);
    return {addr, I2C_WR_BIT};
  endfunction

endpackage

// File: rtl/i2c_write_sequencer_if.sv
// Host command/FIFO port plus the I2C_Master command/status port, bundled.
// Master-side signal names match I2C_Master so the blocks connect by name.
interface i2c_write_sequencer_if
  import i2c_seq_pkg::*;
#(
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) ();

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [6:0]       cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [7:0]       wdata;
  logic             wdata_valid;
  logic             wdata_ready;
  logic [LVL_W-1:0] fifo_level;
  logic             busy;
  logic             done;
  logic             err;
  logic             start;
  logic             stop;
  logic             i2c_en;
  logic [7:0]       tx_data;
  logic             ready;
  logic             tx_done;

  // The sequencer side.
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, wdata, wdata_valid, ready, tx_done,
    output cmd_ready, wdata_ready, fifo_level, busy, done, err,
           start, stop, i2c_en, tx_data
  );

  // The host plus I2C_Master side.
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, wdata, wdata_valid, ready, tx_done,
    input  cmd_ready, wdata_ready, fifo_level, busy, done, err,
           start, stop, i2c_en, tx_data
  );

endinterface

// File: rtl/i2c_seq_fifo.sv
// Synchronous write-data FIFO: push/pop/flush, occupancy level, full/empty.
// A push while full is dropped; a pop while empty is ignored.
module i2c_seq_fifo
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head,
  output logic [AW:0]  level,
  output logic         full,
  output logic         empty
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok, pop_ok;
  logic [W-1:0]  mem [DEPTH];

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign level   = level_q;
  assign head    = mem[rd_ptr_q];

  // Storage is not reset; only the pointers define what is valid.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    logic [W-1:0] entry_q;
    always_ff @(posedge clk) begin
      if (push_ok && (wr_ptr_q == AW'(gi))) begin
        entry_q <= din;
      end
    end
    assign mem[gi] = entry_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/i2c_write_sequencer.sv
// Sequences START+address, N FIFO bytes and STOP through an I2C_Master.
// Define I2C_SEQ_TIMEOUT_EN to add the per-state watchdog and sticky err flag.
module i2c_write_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input logic                   clk,
  input logic                   reset_n,
  i2c_write_sequencer_if.master bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  seq_state_e       state_q, state_d;
  logic [6:0]       addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             start_q, start_d;
  logic             stop_q, stop_d;
  logic             i2c_en_q, i2c_en_d;
  logic             done_q, done_d;
  logic             low_seen_q, low_seen_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic             fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic [LVL_W-1:0] fifo_level;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timeout;
  // Fires on the edge at which the counter would reach TIMEOUT_CYC.
  assign timeout = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  i2c_seq_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (bus.wdata_valid),
    .din     (bus.wdata),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .head    (fifo_head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    start_d    = start_q;
    stop_d     = stop_q;
    tx_data_d  = tx_data_q;
    low_seen_d = low_seen_q;
    i2c_en_d   = 1'b0;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
    err_d      = err_q;
    cnt_d      = '0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          rem_d   = bus.cmd_len;
          state_d = ADDR_REQ;
`ifdef I2C_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ADDR_REQ: begin
        if (bus.ready) begin
          i2c_en_d  = 1'b1;
          start_d   = 1'b1;
          stop_d    = 1'b0;
          tx_data_d = addr_byte(addr_q);
          state_d   = ADDR_WAIT;
        end
      end
      ADDR_WAIT: begin
        if (bus.tx_done) begin
          state_d = (rem_q != '0) ? DATA_REQ : STOP_REQ;
        end
      end
      DATA_REQ: begin
        // An empty FIFO simply stalls here until the host pushes more.
        if (bus.ready && !fifo_empty) begin
          i2c_en_d  = 1'b1;
          start_d   = 1'b0;
          stop_d    = 1'b0;
          tx_data_d = fifo_head;
          fifo_pop  = 1'b1;
          state_d   = DATA_WAIT;
        end
      end
      DATA_WAIT: begin
        if (bus.tx_done) begin
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q != LEN_W'(1)) ? DATA_REQ : STOP_REQ;
        end
      end
      STOP_REQ: begin
        if (bus.ready) begin
          i2c_en_d   = 1'b1;
          start_d    = 1'b0;
          stop_d     = 1'b1;
          low_seen_d = 1'b0;
          state_d    = STOP_WAIT;
        end
      end
      STOP_WAIT: begin
        // The STOP is on the bus once ready has dropped and come back.
        if (!bus.ready) begin
          low_seen_d = 1'b1;
        end else if (low_seen_q) begin
          done_d  = 1'b1;
          stop_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef I2C_SEQ_TIMEOUT_EN
    if (timeout) begin
      err_d      = 1'b1;
      fifo_flush = 1'b1;
      fifo_pop   = 1'b0;
      i2c_en_d   = 1'b0;
      done_d     = 1'b0;
      start_d    = start_q;
      stop_d     = stop_q;
      tx_data_d  = tx_data_q;
      rem_d      = rem_q;
      state_d    = (state_q == STOP_REQ || state_q == STOP_WAIT) ? IDLE : STOP_REQ;
    end
    if (state_d == state_q && state_q != IDLE) begin
      cnt_d = cnt_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      tx_data_q  <= '0;
      i2c_en_q   <= 1'b0;
      done_q     <= 1'b0;
      low_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      tx_data_q  <= tx_data_d;
      i2c_en_q   <= i2c_en_d;
      done_q     <= done_d;
      low_seen_q <= low_seen_d;
    end
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.start       = start_q;
  assign bus.stop        = stop_q;
  assign bus.i2c_en      = i2c_en_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.wdata_ready = !fifo_full;
  assign bus.fifo_level  = fifo_level;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Directed bench for i2c_write_sequencer with a scoreboard of expected master strobes.
// The timeout scenario is exercised only when I2C_SEQ_TIMEOUT_EN is defined.
module tb_i2c_write_sequencer;
  import i2c_seq_pkg::*;

  localparam int FD   = 8;
  localparam int LW   = 4;
  localparam int MLAT = 3;
`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TO = 64;
`else
  localparam int TO = 100000;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  i2c_write_sequencer_if #(.LEN_W(LW), .FIFO_DEPTH(FD)) bus ();

  i2c_write_sequencer #(.FIFO_DEPTH(FD), .LEN_W(LW), .TIMEOUT_CYC(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;
  bit drop_tx_done = 1'b0;
  logic [9:0] exp_q [$];   // {start, stop, tx_data} per expected i2c_en strobe

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.wdata       = b;
    bus.wdata_valid = 1'b1;
    step(1);
    bus.wdata_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [6:0] a, input logic [LW-1:0] l);
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    bus.cmd_valid = 1'b1;
    step(1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    chk({tag, "_done"}, done_cnt, target);
  endtask

  task automatic wait_strobes(input string tag, input int target, input int budget);
    int n = 0;
    while (strobe_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    chk({tag, "_strobes"}, strobe_cnt, target);
  endtask

  // Behavioural I2C_Master: busy for MLAT cycles after each command strobe.
  initial begin
    bit is_stop;
    bus.ready   = 1'b1;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (bus.i2c_en) begin
        is_stop   = bus.stop;
        bus.ready = 1'b0;
        repeat (MLAT) @(negedge clk);
        if (!is_stop && !drop_tx_done) bus.tx_done = 1'b1;
        bus.ready = 1'b1;
      end
    end
  end

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    logic [9:0] e;
    if (reset_n) begin
      if (bus.i2c_en) begin
        strobe_cnt++;
        $display("[TB] strobe start=%0b stop=%0b tx_data=0x%02h", bus.start, bus.stop, bus.tx_data);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {22'd0, bus.start, bus.stop, bus.tx_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("strobe", {22'd0, bus.start, bus.stop, bus.tx_data}, {22'd0, e});
        end
      end
      if (bus.done) done_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sb, db;
    bus.cmd_valid   = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_len     = '0;
    bus.wdata       = '0;
    bus.wdata_valid = 1'b0;
    #2 reset_n = 1'b0;
    step(3);

    chk("rst_cmd_ready",   bus.cmd_ready, 1);
    chk("rst_wdata_ready", bus.wdata_ready, 1);
    chk("rst_level",       bus.fifo_level, 0);
    chk("rst_busy",        bus.busy, 0);
    chk("rst_done",        bus.done, 0);
    chk("rst_err",         bus.err, 0);
    chk("rst_ctl",         {bus.start, bus.stop, bus.i2c_en}, 0);
    chk("rst_tx_data",     bus.tx_data, 0);
    reset_n = 1'b1;
    step(2);

    // Two data bytes to address 0x55.
    push(8'hAA);
    push(8'hFF);
    chk("t1_level", bus.fifo_level, 2);
    exp_q.push_back({1'b1, 1'b0, 8'hAA});
    exp_q.push_back({1'b0, 1'b0, 8'hAA});
    exp_q.push_back({1'b0, 1'b0, 8'hFF});
    exp_q.push_back({1'b0, 1'b1, 8'hFF});
    sb = strobe_cnt;
    db = done_cnt;
    send_cmd(7'h55, 4'd2);
    chk("t1_busy", bus.busy, 1);
    wait_done("t1", db + 1, 300);
    step(5);
    chk("t1_one_done", done_cnt, db + 1);
    chk("t1_strobes",  strobe_cnt - sb, 4);
    chk("t1_level_end", bus.fifo_level, 0);
    chk("t1_stop_clr",  bus.stop, 0);
    chk("t1_exp_empty", exp_q.size(), 0);

    // Address-only write.
    exp_q.push_back({1'b1, 1'b0, 8'hA0});
    exp_q.push_back({1'b0, 1'b1, 8'hA0});
    sb = strobe_cnt;
    db = done_cnt;
    send_cmd(7'h50, 4'd0);
    wait_done("t2", db + 1, 300);
    step(5);
    chk("t2_strobes", strobe_cnt - sb, 2);
    chk("t2_one_done", done_cnt, db + 1);

    // Starved FIFO: stall in DATA_REQ, then resume in push order.
    push(8'h11);
    exp_q.push_back({1'b1, 1'b0, 8'h40});
    exp_q.push_back({1'b0, 1'b0, 8'h11});
    exp_q.push_back({1'b0, 1'b0, 8'h22});
    exp_q.push_back({1'b0, 1'b0, 8'h33});
    exp_q.push_back({1'b0, 1'b1, 8'h33});
    sb = strobe_cnt;
    db = done_cnt;
    send_cmd(7'h20, 4'd3);
    step(50);
    chk("t3_stall_strobes", strobe_cnt - sb, 2);
    chk("t3_busy",          bus.busy, 1);
    chk("t3_cmd_ready",     bus.cmd_ready, 0);
    send_cmd(7'h7F, 4'd1);   // must be ignored while busy
    push(8'h22);
    push(8'h33);
    wait_done("t3", db + 1, 300);
    step(5);
    chk("t3_strobes", strobe_cnt - sb, 5);
    chk("t3_level_end", bus.fifo_level, 0);

    // Overfill: ninth push dropped; drain all eight to prove it.
    for (int i = 0; i < 9; i++) begin
      push(8'(8'h80 + i));
      if (i == 7) chk("t4_ready_full", bus.wdata_ready, 0);
    end
    chk("t4_level_full", bus.fifo_level, 8);
    exp_q.push_back({1'b1, 1'b0, 8'h66});
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 1'b0, 8'(8'h80 + i)});
    exp_q.push_back({1'b0, 1'b1, 8'h87});
    sb = strobe_cnt;
    db = done_cnt;
    send_cmd(7'h33, 4'd8);
    wait_done("t4", db + 1, 600);
    step(5);
    chk("t4_strobes", strobe_cnt - sb, 10);
    chk("t4_level_end", bus.fifo_level, 0);

    // Asynchronous reset while waiting for a data byte.
    push(8'h91);
    push(8'h92);
    exp_q.push_back({1'b1, 1'b0, 8'h66});
    exp_q.push_back({1'b0, 1'b0, 8'h91});
    sb = strobe_cnt;
    send_cmd(7'h33, 4'd2);
    wait_strobes("t5", sb + 2, 200);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_ctl",   {bus.start, bus.stop, bus.i2c_en, bus.done}, 0);
    chk("t5_rst_tx",    bus.tx_data, 0);
    chk("t5_rst_busy",  bus.busy, 0);
    chk("t5_rst_level", bus.fifo_level, 0);
    chk("t5_rst_wrdy",  bus.wdata_ready, 1);
    exp_q.delete();
    step(2);
    reset_n = 1'b1;
    step(10);
    chk("t5_cmd_ready", bus.cmd_ready, 1);
    chk("t5_level",     bus.fifo_level, 0);

`ifdef I2C_SEQ_TIMEOUT_EN
    // Slave never completes the address byte.
    push(8'hC1);
    push(8'hC2);
    drop_tx_done = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 8'h24});
    exp_q.push_back({1'b0, 1'b1, 8'h24});
    sb = strobe_cnt;
    db = done_cnt;
    send_cmd(7'h12, 4'd2);
    wait_strobes("t6_addr", sb + 1, 100);
    step(TO - 1);
    chk("t6_err_early", bus.err, 0);
    step(1);
    chk("t6_err",   bus.err, 1);
    chk("t6_flush", bus.fifo_level, 0);
    wait_done("t6", db + 1, 100);
    chk("t6_strobes", strobe_cnt - sb, 2);
    chk("t6_err_sticky", bus.err, 1);
    drop_tx_done = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 8'hA0});
    exp_q.push_back({1'b0, 1'b1, 8'hA0});
    db = done_cnt;
    send_cmd(7'h50, 4'd0);
    chk("t6_err_clear", bus.err, 0);
    wait_done("t6b", db + 1, 300);
`endif

    step(5);
    chk("final_err", bus.err, 0);
    chk("final_exp_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
